// File: rtl/ctrl_seq.sv
// Eight-phase controller/sequencer for the accumulator CPU, with sticky halt and a retired-instruction counter.
// Optional feature: define CTRL_RESUME_EN to let a resume pulse release the halted state.

package ctrl_seq_pkg;
    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;
endpackage

module ctrl_seq
    import ctrl_seq_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  opcode_t          opcode,
    input  logic             zero,
    input  logic             resume,
    output logic             sel,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             load_ir,
    output logic             load_ac,
    output logic             load_pc,
    output logic             inc_pc,
    output logic             data_e,
    output logic             halt,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    phase_t            phase_q, phase_d;
    logic              halted_q, halted_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              aluop;

`ifndef CTRL_RESUME_EN
    logic unused_resume;
    assign unused_resume = resume;
`endif

    // HLT retires on the same edge that freezes the sequencer at OP_ADDR.
    always_comb begin
        phase_d  = phase_q;
        halted_d = halted_q;
        cnt_d    = cnt_q;
        if (halted_q) begin
`ifdef CTRL_RESUME_EN
            if (resume) begin
                halted_d = 1'b0;
                phase_d  = INST_ADDR;
            end
`endif
        end else if (phase_q == OP_ADDR && opcode == HLT) begin
            halted_d = 1'b1;
            cnt_d    = cnt_q + CNT_W'(1);
        end else begin
            phase_d = phase_t'(3'(phase_q + 3'd1));
            if (phase_q == STORE) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= INST_ADDR;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

    assign aluop = (opcode inside {ADD, AND, XOR, LDA});

    always_comb begin
        sel     = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        load_ir = 1'b0;
        load_ac = 1'b0;
        load_pc = 1'b0;
        inc_pc  = 1'b0;
        data_e  = 1'b0;
        halt    = 1'b0;
        if (halted_q) begin
            halt = 1'b1;
        end else begin
            case (phase_q)
                INST_ADDR: sel = 1'b1;
                INST_FETCH: begin
                    sel    = 1'b1;
                    mem_rd = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel     = 1'b1;
                    mem_rd  = 1'b1;
                    load_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = (opcode == HLT);
                end
                OP_FETCH: mem_rd = aluop;
                ALU_OP: begin
                    mem_rd  = aluop;
                    load_ac = aluop;
                    load_pc = (opcode == JMP);
                    inc_pc  = (opcode == SKZ) && zero;
                end
                STORE: begin
                    mem_rd  = aluop;
                    load_ac = aluop;
                    load_pc = (opcode == JMP);
                    inc_pc  = (opcode == JMP);
                    mem_wr  = (opcode == STO);
                    data_e  = (opcode == STO);
                end
                default: ;
            endcase
        end
    end

    assign phase     = phase_q;
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed testbench for ctrl_seq; a second CNT_W=4 instance shares all stimulus for the counter-wrap check.
// Honours CTRL_RESUME_EN when choosing the expected post-resume behaviour.

module tb_ctrl_seq;
    import ctrl_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    opcode_t    opcode = ADD;
    logic       zero = 1'b0;
    logic       resume = 1'b0;

    logic sel, mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc, data_e, halt;
    logic [2:0]  phase;
    logic [15:0] instr_cnt;

    logic unused_sel4, unused_rd4, unused_wr4, unused_ir4, unused_ac4;
    logic unused_pc4, unused_inc4, unused_de4, unused_halt4;
    logic [2:0] unused_phase4;
    logic [3:0] cnt4;

    logic [8:0] strobes;
    assign strobes = {sel, mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc, data_e, halt};

    int checks = 0;
    int fails  = 0;
    int exp_cnt;

    always #5 clk = ~clk;

    ctrl_seq dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .resume(resume),
        .sel(sel), .mem_rd(mem_rd), .mem_wr(mem_wr), .load_ir(load_ir),
        .load_ac(load_ac), .load_pc(load_pc), .inc_pc(inc_pc), .data_e(data_e),
        .halt(halt), .phase(phase), .instr_cnt(instr_cnt)
    );

    ctrl_seq #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .resume(resume),
        .sel(unused_sel4), .mem_rd(unused_rd4), .mem_wr(unused_wr4), .load_ir(unused_ir4),
        .load_ac(unused_ac4), .load_pc(unused_pc4), .inc_pc(unused_inc4), .data_e(unused_de4),
        .halt(unused_halt4), .phase(unused_phase4), .instr_cnt(cnt4)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        opcode = ADD;
        zero = 1'b0;
        tick();
        checks++;
        if (strobes !== 9'h100) begin fails++; $display("[TB] FAIL reset_strobes: got %h expected %h", strobes, 9'h100); end
        checks++;
        if (phase !== 3'd0) begin fails++; $display("[TB] FAIL reset_phase: got %0d expected 0", phase); end
        checks++;
        if (instr_cnt !== 16'd0) begin fails++; $display("[TB] FAIL reset_cnt: got %0d expected 0", instr_cnt); end
        rst = 1'b0;
        #1;
    endtask

    task automatic test_add();
        logic [8:0] exp [8];
        exp = '{9'h100, 9'h180, 9'h1A0, 9'h1A0, 9'h004, 9'h080, 9'h090, 9'h090};
        opcode = ADD;
        zero = 1'b0;
        do_reset();
        for (int p = 0; p < 8; p++) begin
            checks++;
            if (phase !== 3'(p)) begin fails++; $display("[TB] FAIL add_phase: got %0d expected %0d", phase, p); end
            checks++;
            if (strobes !== exp[p]) begin fails++; $display("[TB] FAIL add_strobes p%0d: got %h expected %h", p, strobes, exp[p]); end
            tick();
        end
        checks++;
        if (instr_cnt !== 16'd1) begin fails++; $display("[TB] FAIL add_cnt: got %0d expected 1", instr_cnt); end
        checks++;
        if (phase !== 3'd0) begin fails++; $display("[TB] FAIL add_wrap_phase: got %0d expected 0", phase); end
    endtask

    task automatic test_sto();
        logic [8:0] exp [8];
        exp = '{9'h100, 9'h180, 9'h1A0, 9'h1A0, 9'h004, 9'h000, 9'h000, 9'h042};
        opcode = STO;
        zero = 1'b1;
        do_reset();
        for (int p = 0; p < 8; p++) begin
            checks++;
            if (strobes !== exp[p]) begin fails++; $display("[TB] FAIL sto_strobes p%0d: got %h expected %h", p, strobes, exp[p]); end
            tick();
        end
    endtask

    task automatic test_skz();
        logic [8:0] exp [16];
        exp = '{9'h100, 9'h180, 9'h1A0, 9'h1A0, 9'h004, 9'h000, 9'h004, 9'h000,
                9'h100, 9'h180, 9'h1A0, 9'h1A0, 9'h004, 9'h000, 9'h000, 9'h000};
        opcode = SKZ;
        do_reset();
        for (int p = 0; p < 16; p++) begin
            zero = (p < 8);
            #1;
            checks++;
            if (strobes !== exp[p]) begin fails++; $display("[TB] FAIL skz_strobes step%0d: got %h expected %h", p, strobes, exp[p]); end
            tick();
        end
        checks++;
        if (instr_cnt !== 16'd2) begin fails++; $display("[TB] FAIL skz_cnt: got %0d expected 2", instr_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp [16];
        exp = '{9'h100, 9'h180, 9'h1A0, 9'h1A0, 9'h004, 9'h000, 9'h008, 9'h00C,
                9'h100, 9'h180, 9'h1A0, 9'h1A0, 9'h004, 9'h080, 9'h090, 9'h090};
        do_reset();
        for (int p = 0; p < 16; p++) begin
            opcode = (p < 8) ? JMP : LDA;
            #1;
            checks++;
            if (strobes !== exp[p]) begin fails++; $display("[TB] FAIL jmp_lda_strobes step%0d: got %h expected %h", p, strobes, exp[p]); end
            tick();
        end
        checks++;
        if (instr_cnt !== 16'd2) begin fails++; $display("[TB] FAIL jmp_lda_cnt: got %0d expected 2", instr_cnt); end
    endtask

    task automatic test_halt();
        logic [8:0] exp [5];
        exp = '{9'h100, 9'h180, 9'h1A0, 9'h1A0, 9'h005};
        opcode = HLT;
        zero = 1'b0;
        do_reset();
        for (int p = 0; p < 5; p++) begin
            checks++;
            if (strobes !== exp[p]) begin fails++; $display("[TB] FAIL hlt_strobes p%0d: got %h expected %h", p, strobes, exp[p]); end
            tick();
        end
        exp_cnt = 1;
        for (int i = 0; i < 20; i++) begin
            opcode = opcode_t'(i[2:0]);
            zero = i[0];
            #1;
            checks++;
            if (phase !== 3'd4 || strobes !== 9'h001) begin
                fails++;
                $display("[TB] FAIL hlt_frozen c%0d: got phase %0d strobes %h expected phase 4 strobes 001", i, phase, strobes);
            end
            tick();
        end
        checks++;
        if (instr_cnt !== 16'(exp_cnt)) begin fails++; $display("[TB] FAIL hlt_cnt: got %0d expected %0d", instr_cnt, exp_cnt); end
        opcode = ADD;
        resume = 1'b1;
        tick();
        resume = 1'b0;
        #1;
`ifdef CTRL_RESUME_EN
        checks++;
        if (phase !== 3'd0 || strobes !== 9'h100) begin
            fails++;
            $display("[TB] FAIL resume: got phase %0d strobes %h expected phase 0 strobes 100", phase, strobes);
        end
`else
        checks++;
        if (phase !== 3'd4 || strobes !== 9'h001) begin
            fails++;
            $display("[TB] FAIL sticky_halt: got phase %0d strobes %h expected phase 4 strobes 001", phase, strobes);
        end
`endif
        checks++;
        if (instr_cnt !== 16'(exp_cnt)) begin fails++; $display("[TB] FAIL resume_cnt: got %0d expected %0d", instr_cnt, exp_cnt); end
    endtask

    task automatic test_async_reset();
        opcode = ADD;
        zero = 1'b0;
        do_reset();
        repeat (14) tick();
        checks++;
        if (phase !== 3'd6 || load_ac !== 1'b1 || instr_cnt !== 16'd1) begin
            fails++;
            $display("[TB] FAIL pre_reset: got phase %0d load_ac %b cnt %0d expected 6 1 1", phase, load_ac, instr_cnt);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (strobes !== 9'h100 || phase !== 3'd0 || instr_cnt !== 16'd0) begin
            fails++;
            $display("[TB] FAIL async_reset: got strobes %h phase %0d cnt %0d expected 100 0 0", strobes, phase, instr_cnt);
        end
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_cnt_wrap();
        opcode = ADD;
        do_reset();
        repeat (120) tick();
        checks++;
        if (cnt4 !== 4'd15) begin fails++; $display("[TB] FAIL cnt4_15: got %0d expected 15", cnt4); end
        repeat (8) tick();
        checks++;
        if (cnt4 !== 4'd0) begin fails++; $display("[TB] FAIL cnt4_wrap: got %0d expected 0", cnt4); end
        checks++;
        if (instr_cnt !== 16'd16) begin fails++; $display("[TB] FAIL cnt16: got %0d expected 16", instr_cnt); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sto();
        test_skz();
        test_back_to_back();
        test_halt();
        test_async_reset();
        test_cnt_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation ran past 100000 time units");
        $fatal(1, "[TB] timeout");
    end

endmodule
